// File: rtl/voting_pkg.sv
// Shared types and sizing helpers for the ballot tally block.
// Latency: none (package only).
// Backpressure: none (package only).
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default sizing; instances recompute these from their own parameters.
    localparam int N_DEF = 2;
    localparam int M_DEF = 2;
    localparam int NC    = 1 << N_DEF;
    localparam int NV    = 1 << M_DEF;
    localparam int CW    = M_DEF + 1;

    // One ballot per voter caps a count at 2**m, which needs m+1 bits.
    function automatic int count_width(input int m);
        return m + 1;
    endfunction

endpackage

// File: rtl/voting_scan.sv
// Sequential argmax over the tally array, one candidate per cycle, lowest index wins ties.
// Latency: go at edge t, index k evaluated at edge t+1+k, done pulses after edge t+NC.
// Backpressure: none; clr aborts a scan and clears the held result at once.
module voting_scan
    import voting_pkg::*;
#(
    parameter int N  = 2,
    parameter int CW = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     go,
    input  logic [(1<<N)-1:0][CW-1:0] tally,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0]             winner,
    output logic [CW-1:0]            best,
    output logic                     tie
);

    localparam int           NCS  = 1 << N;
    localparam logic [N-1:0] LAST = N'(NCS - 1);

    logic [N-1:0]  idx;
    logic [CW-1:0] cur;

    assign cur = tally[idx];

    // Walk the candidates, keeping the running maximum and a tie flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
            winner <= '0;
            best   <= '0;
            tie    <= 1'b0;
        end else if (clr) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
            winner <= '0;
            best   <= '0;
            tie    <= 1'b0;
        end else if (go) begin
            busy   <= 1'b1;
            done   <= 1'b0;
            idx    <= '0;
            winner <= '0;
            best   <= '0;
            tie    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (cur > best) begin
                    best   <= cur;
                    winner <= idx;
                    tie    <= 1'b0;
                end else if (cur == best && idx != '0) begin
                    tie <= 1'b1;
                end
                if (idx == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + N'(1);
                end
            end
        end
    end

endmodule

// File: rtl/voting_tally.sv
// Ballot intake with duplicate-voter rejection, per-candidate tallies and an argmax scan on close.
// Latency: ballot counted at next edge; done rises 2**N+1 edges after close is taken.
// Backpressure: vote_ready is high only while balloting is open; one ballot per cycle.
module voting_tally
    import voting_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      vote_valid,
    output logic                      vote_ready,
    input  logic [N-1:0]              vote_cand,
    input  logic [M-1:0]              vote_voter,
    input  logic                      close,
    output logic                      rejected,
    output logic [count_width(M)-1:0] n_votes,
    output logic                      done,
    output logic [N-1:0]              winner,
    output logic [count_width(M)-1:0] winner_count,
    output logic                      tie
);

    localparam int TNC = 1 << N;
    localparam int TNV = 1 << M;
    localparam int TCW = count_width(M);

    state_t                    state;
    logic [TNC-1:0][TCW-1:0]   tally;
    logic [TNV-1:0]            bitmap;
    logic                      hs;
    logic                      scan_go;
    logic                      scan_busy;
    logic                      scan_done;

    // vote_ready is a registered decode of OPEN, so it gates the handshake directly.
    assign hs      = vote_valid & vote_ready;
    // start wins over close, so an aborting start never launches a scan.
    assign scan_go = (state == OPEN) & close & ~start;

    // Election FSM with ballot bookkeeping; start aborts from any non-idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tally      <= '0;
            bitmap     <= '0;
            n_votes    <= '0;
            rejected   <= 1'b0;
            vote_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            rejected <= 1'b0;
            if (start) begin
                state      <= OPEN;
                tally      <= '0;
                bitmap     <= '0;
                n_votes    <= '0;
                vote_ready <= 1'b1;
                done       <= 1'b0;
            end else begin
                case (state)
                    OPEN: begin
                        if (hs) begin
                            if (bitmap[vote_voter]) begin
                                rejected <= 1'b1;
                            end else begin
                                bitmap[vote_voter] <= 1'b1;
                                tally[vote_cand]   <= tally[vote_cand] + TCW'(1);
                                n_votes            <= n_votes + TCW'(1);
                            end
                        end
                        if (close) begin
                            state      <= SCAN;
                            vote_ready <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (scan_done && !scan_busy) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    voting_scan #(
        .N  (N),
        .CW (TCW)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .go     (scan_go),
        .tally  (tally),
        .busy   (scan_busy),
        .done   (scan_done),
        .winner (winner),
        .best   (winner_count),
        .tie    (tie)
    );

endmodule

// File: tb/tb_voting_tally.sv
module tb_voting_tally;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       vote_valid;
    logic       vote_ready;
    logic [1:0] vote_cand;
    logic [1:0] vote_voter;
    logic       close;
    logic       rejected;
    logic [2:0] n_votes;
    logic       done;
    logic [1:0] winner;
    logic [2:0] winner_count;
    logic       tie;

    int n_cmp;
    int n_bad;

    voting_tally #(.N(2), .M(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vote_valid   (vote_valid),
        .vote_ready   (vote_ready),
        .vote_cand    (vote_cand),
        .vote_voter   (vote_voter),
        .close        (close),
        .rejected     (rejected),
        .n_votes      (n_votes),
        .done         (done),
        .winner       (winner),
        .winner_count (winner_count),
        .tie          (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One ballot presented for exactly one rising edge; sampled at the following negedge.
    task automatic vote(input logic [1:0] c, input logic [1:0] v);
        @(negedge clk);
        vote_valid = 1'b1;
        vote_cand  = c;
        vote_voter = v;
        @(negedge clk);
        vote_valid = 1'b0;
    endtask

    // Pulse close (optionally with a ballot in the same cycle) and count cycles to done.
    task automatic close_wait(input string tag, input bit with_vote,
                              input logic [1:0] c, input logic [1:0] v);
        int cnt;
        @(negedge clk);
        close = 1'b1;
        if (with_vote) begin
            vote_valid = 1'b1;
            vote_cand  = c;
            vote_voter = v;
        end
        @(negedge clk);
        close      = 1'b0;
        vote_valid = 1'b0;
        cnt = 0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 5);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        vote_valid = 1'b0;
        vote_cand  = '0;
        vote_voter = '0;
        close      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_ready", vote_ready, 0);
        chk("rst_rejected", rejected, 0);
        chk("rst_nvotes", n_votes, 0);
        chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);
        chk("rst_wcount", winner_count, 0);
        chk("rst_tie", tie, 0);
        rst_n = 1'b1;

        // close in IDLE and ballots in IDLE are ignored
        @(negedge clk);
        close      = 1'b1;
        vote_valid = 1'b1;
        @(negedge clk);
        close      = 1'b0;
        vote_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_close_done", done, 0);
        chk("idle_ready", vote_ready, 0);
        chk("idle_rejected", rejected, 0);

        // Async reset mid-OPEN after two ballots
        pulse_start();
        chk("open_ready", vote_ready, 1);
        vote(2'd1, 2'd0);
        vote(2'd2, 2'd1);
        chk("pre_rst_nvotes", n_votes, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", vote_ready, 0);
        chk("midrst_nvotes", n_votes, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        chk("post_rst_nvotes", n_votes, 0);

        // Basic: votes 2,2,1,3 -> winner 2 with 2
        vote(2'd2, 2'd0);
        vote(2'd2, 2'd1);
        vote(2'd1, 2'd2);
        vote(2'd3, 2'd3);
        chk("basic_rejected", rejected, 0);
        close_wait("basic", 1'b0, 2'd0, 2'd0);
        chk("basic_done", done, 1);
        chk("basic_winner", winner, 2);
        chk("basic_wcount", winner_count, 2);
        chk("basic_tie", tie, 0);
        chk("basic_nvotes", n_votes, 4);
        chk("basic_ready", vote_ready, 0);
        // A repeat voter in DONE is ignored without a rejected pulse
        vote(2'd0, 2'd0);
        chk("done_vote_rejected", rejected, 0);
        chk("done_vote_nvotes", n_votes, 4);
        chk("done_hold", done, 1);

        // Duplicate voter
        pulse_start();
        chk("restart_done", done, 0);
        vote(2'd3, 2'd1);
        chk("dup_first_rej", rejected, 0);
        vote(2'd0, 2'd1);
        chk("dup_second_rej", rejected, 1);
        @(negedge clk);
        chk("dup_rej_pulse", rejected, 0);
        chk("dup_nvotes", n_votes, 1);
        close_wait("dup", 1'b0, 2'd0, 2'd0);
        chk("dup_winner", winner, 3);
        chk("dup_wcount", winner_count, 1);
        chk("dup_tie", tie, 0);

        // Tie: 1,3,3,1
        pulse_start();
        vote(2'd1, 2'd0);
        vote(2'd3, 2'd1);
        vote(2'd3, 2'd2);
        vote(2'd1, 2'd3);
        close_wait("tie", 1'b0, 2'd0, 2'd0);
        chk("tie_winner", winner, 1);
        chk("tie_wcount", winner_count, 2);
        chk("tie_tie", tie, 1);

        // Empty election
        pulse_start();
        close_wait("empty", 1'b0, 2'd0, 2'd0);
        chk("empty_winner", winner, 0);
        chk("empty_wcount", winner_count, 0);
        chk("empty_tie", tie, 1);
        chk("empty_nvotes", n_votes, 0);

        // Ballot in the same cycle as close is counted
        pulse_start();
        close_wait("cv", 1'b1, 2'd2, 2'd0);
        chk("cv_winner", winner, 2);
        chk("cv_wcount", winner_count, 1);
        chk("cv_tie", tie, 0);
        chk("cv_nvotes", n_votes, 1);

        // Abort during SCAN
        pulse_start();
        vote(2'd1, 2'd0);
        @(negedge clk);
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
        @(negedge clk);
        chk("abort_scan_ready", vote_ready, 0);
        pulse_start();
        chk("abort_ready", vote_ready, 1);
        chk("abort_nvotes", n_votes, 0);
        chk("abort_wcount", winner_count, 0);
        repeat (6) @(negedge clk);
        chk("abort_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
